fft_input_buffer: RTL and testbench

Ping-pong sample buffer that sits directly upstream of the FFT stage counter and butterfly datapath. It accepts a stream of complex samples over a valid/ready handshake and writes each 256-point frame into a free bank in bit-reversed order. When a bank is full, it issues a one-cycle `frame_start` to the downstream stage controller. The downstream stage then reads the bank by address and releases it with `frame_done`.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_bank_ram.sv | 41 ++++
 rtl/fft_input_buffer.sv | 174 +++++++++++++++++
 tb/tb_fft_input_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT input buffer.
//   LOG2N / N / DATA_W : frame geometry and sample component width
//   bank_state_t       : ownership state of one ping-pong bank
//   rd_state_t         : read-side hand-off FSM states
//   bitrev()           : LOG2N-bit bit reversal used for write addressing
package fft_pkg;

  localparam int LOG2N  = 8;
  localparam int N      = 1 << LOG2N;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_OWNED = 2'd2
  } bank_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// fft_bank_ram: simple dual-port RAM holding both ping-pong banks.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data written on the rising edge
//   rd_en   : read strobe, rd_data updates on the rising edge (registered)
//   rd_addr : {bank, addr} read address
// Contents are never reset so the array maps onto block RAM.
module fft_bank_ram
  import fft_pkg::*;
#(
  parameter int ADDR_W = LOG2N + 1,
  parameter int WIDTH  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fft_input_buffer.sv
// fft_input_buffer: ping-pong frame buffer in front of the FFT datapath.
//   in_valid/in_ready/in_re/in_im/in_last : upstream sample stream
//   frame_start : one-cycle pulse when a full bank is handed downstream
//   busy        : downstream currently owns a bank
//   rd_en/rd_addr -> rd_re/rd_im : natural-order reads of the owned bank
//   frame_done  : downstream releases the owned bank
//   occupancy   : banks not FREE (0..2)
//   frame_err   : sticky, a frame was cut short by an early in_last
// Samples are stored at bit-reversed addresses so natural-order reads
// come out in the order the butterflies want.
module fft_input_buffer #(
  parameter int LOG2N  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_last,
  output logic              frame_start,
  output logic              busy,
  input  logic              rd_en,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  input  logic              frame_done,
  output logic [1:0]        occupancy,
  output logic              frame_err
);

  import fft_pkg::*;

  bank_state_t       bank_state_reg  [2];
  bank_state_t       bank_state_next [2];
  rd_state_t         rd_state_reg;
  logic              wr_bank_reg;
  logic              rd_bank_reg;
  logic [LOG2N-1:0]  wr_cnt_reg;
  logic              frame_start_reg;
  logic              frame_err_reg;
  logic              rd_pending_reg;
  logic [DATA_W-1:0] rd_re_reg;
  logic [DATA_W-1:0] rd_im_reg;

  logic                accept;
  logic                last_accept;
  logic                claim;
  logic                release_bank;
  logic                ram_rd_en;
  logic [LOG2N:0]      ram_wr_addr;
  logic [2*DATA_W-1:0] ram_rd_data;

  assign in_ready     = ~rst & (bank_state_reg[wr_bank_reg] == BANK_FREE);
  assign accept       = in_valid & in_ready;
  assign last_accept  = accept & (&wr_cnt_reg);
  // A frame completing into the bank the idle reader waits on is claimed on
  // the same edge, so frame_start follows the last accept by one cycle.
  // After a release the reader first re-enters IDLE, then claims next edge.
  assign claim        = (rd_state_reg == RD_IDLE) &
                        ((bank_state_reg[rd_bank_reg] == BANK_FULL) |
                         (last_accept & (wr_bank_reg == rd_bank_reg)));
  assign release_bank = (rd_state_reg == RD_BUSY) & frame_done;
  assign ram_rd_en    = (rd_state_reg == RD_BUSY) & rd_en;
  assign ram_wr_addr  = {wr_bank_reg, bitrev(wr_cnt_reg)};

  // Per-bank next state. Fill (from FREE), claim (from FULL or a bank filling
  // this edge) and release (from OWNED) have disjoint preconditions.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    logic sel_wr;
    logic sel_rd;
    assign sel_wr = (wr_bank_reg == 1'(gi));
    assign sel_rd = (rd_bank_reg == 1'(gi));
    assign bank_state_next[gi] = (claim & sel_rd)        ? BANK_OWNED :
                                 (last_accept & sel_wr)  ? BANK_FULL  :
                                 (release_bank & sel_rd) ? BANK_FREE  :
                                                           bank_state_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bank_state_reg[i] <= BANK_FREE;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bank_state_reg[i] <= bank_state_next[i];
      end
    end
  end

  // Write pointer: wraps only on a complete frame or an early in_last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else if (accept) begin
      if (&wr_cnt_reg) begin
        wr_cnt_reg  <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else if (in_last) begin
        wr_cnt_reg    <= '0;
        frame_err_reg <= 1'b1;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  // Read-side hand-off FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg    <= RD_IDLE;
      rd_bank_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      case (rd_state_reg)
        RD_IDLE: begin
          if (claim) begin
            rd_state_reg    <= RD_BUSY;
            frame_start_reg <= 1'b1;
          end
        end
        RD_BUSY: begin
          if (frame_done) begin
            rd_state_reg <= RD_IDLE;
            rd_bank_reg  <= ~rd_bank_reg;
          end
        end
      endcase
    end
  end

  fft_bank_ram #(
    .ADDR_W (LOG2N + 1),
    .WIDTH  (2 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (ram_wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_en   (ram_rd_en),
    .rd_addr ({rd_bank_reg, rd_addr}),
    .rd_data (ram_rd_data)
  );

  // Output stage behind the RAM register: resettable, holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_reg <= 1'b0;
      rd_re_reg      <= '0;
      rd_im_reg      <= '0;
    end else begin
      rd_pending_reg <= ram_rd_en;
      if (rd_pending_reg) begin
        rd_re_reg <= ram_rd_data[2*DATA_W-1:DATA_W];
        rd_im_reg <= ram_rd_data[DATA_W-1:0];
      end
    end
  end

  assign frame_start = frame_start_reg;
  assign busy        = (rd_state_reg == RD_BUSY);
  assign rd_re       = rd_re_reg;
  assign rd_im       = rd_im_reg;
  assign frame_err   = frame_err_reg;
  assign occupancy   = 2'(bank_state_reg[0] != BANK_FREE) +
                       2'(bank_state_reg[1] != BANK_FREE);

endmodule

// File: tb/tb_fft_input_buffer.sv
// tb_fft_input_buffer: directed scoreboard bench for fft_input_buffer.
// Stimulus pushes expected frame_start cycles and expected read data into
// queues; monitors pop and compare when the DUT presents them.
module tb_fft_input_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        in_last = 1'b0;
  logic        frame_start;
  logic        busy;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_re;
  logic [15:0] rd_im;
  logic        frame_done = 1'b0;
  logic [1:0]  occupancy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          exp_fs_q [$];
  logic [31:0] exp_rd_q [$];
  logic        rd_expect = 1'b0;
  logic        rd_d1 = 1'b0;
  logic        rd_d2 = 1'b0;
  int          fs_exp;
  logic [31:0] rd_exp;

  // Hand-computed bit reversals of 8-bit addresses.
  int tbl_addr [8] = '{0, 1, 2, 6, 17, 128, 255, 3};
  int tbl_rev  [8] = '{0, 128, 64, 96, 136, 1, 255, 192};

  fft_input_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_last     (in_last),
    .frame_start (frame_start),
    .busy        (busy),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_re       (rd_re),
    .rd_im       (rd_im),
    .frame_done  (frame_done),
    .occupancy   (occupancy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_d1 <= rd_expect;
    rd_d2 <= rd_d1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // frame_start monitor
  always @(negedge clk) begin
    if (!rst && frame_start) begin
      checks++;
      if (exp_fs_q.size() == 0) begin
        errors++;
        $display("FAIL frame_start_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        fs_exp = exp_fs_q.pop_front();
        if (fs_exp != cyc) begin
          errors++;
          $display("FAIL frame_start_cycle: got cycle %0d, expected %0d", cyc, fs_exp);
        end else begin
          $display("frame_start at cycle %0d", cyc);
        end
      end
    end
  end

  // read data monitor: data for a read sampled at edge t is valid after t+1
  always @(negedge clk) begin
    if (rd_d2) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data_unexpected: re=%0d im=%0d with nothing queued", rd_re, rd_im);
      end else begin
        rd_exp = exp_rd_q.pop_front();
        if ({rd_re, rd_im} !== rd_exp) begin
          errors++;
          $display("FAIL rd_data: got re=%0d im=%0d, expected re=%0d im=%0d",
                   rd_re, rd_im, rd_exp[31:16], rd_exp[15:0]);
        end else begin
          $display("read re=%0d im=%0d", rd_re, rd_im);
        end
      end
    end
  end

  // All tasks below start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im,
                      input logic last, output int edge_idx);
    logic r;
    int waited;
    waited = 0;
    in_valid = 1'b1; in_re = re; in_im = im; in_last = last;
    while (1) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 2000) begin
        checks++; errors++;
        $display("FAIL send_stall: in_ready low for %0d cycles, expected accept", waited);
        break;
      end
    end
    edge_idx = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] tag,
                            input logic last_flag, output int last_edge);
    for (int i = 0; i < n; i++) begin
      send(16'(i), tag, last_flag && (i == n - 1), last_edge);
    end
  endtask

  task automatic do_read(input int addr, input int exp_re, input int exp_im);
    rd_en = 1'b1; rd_addr = 8'(addr); rd_expect = 1'b1;
    exp_rd_q.push_back({16'(exp_re), 16'(exp_im)});
    @(posedge clk);
    #1;
    rd_en = 1'b0; rd_expect = 1'b0;
  endtask

  task automatic read_table(input int tag);
    for (int i = 0; i < 8; i++) begin
      do_read(tbl_addr[i], tbl_rev[i], tag);
    end
    idle(3);
  endtask

  // frame_done sampled at the next edge; expect_fs queues a pulse at t+1.
  task automatic release_frame(input logic expect_fs);
    if (expect_fs) exp_fs_q.push_back(cyc + 2);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_re"}, 32'(rd_re), 0);
    chk({tag, "_rd_im"}, 32'(rd_im), 0);
    chk({tag, "_occupancy"}, 32'(occupancy), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    // ---- reset ----
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 1);
    chk("post_reset_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1;

    // ---- frame A (tag 1) into bank 0, no backpressure ----
    send_frame(256, 16'd1, 1'b1, e);
    exp_fs_q.push_back(e);
    $display("frame A last accept at cycle %0d", e);
    idle(2);
    @(negedge clk);
    chk("A_occupancy", 32'(occupancy), 1);
    chk("A_busy", 32'(busy), 1);
    @(posedge clk); #1;
    read_table(1);
    release_frame(1'b0);
    @(negedge clk);
    chk("A_released_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1;

    // ---- frames B (tag 2) and C (tag 3) fill both banks ----
    send_frame(256, 16'd2, 1'b1, e);
    exp_fs_q.push_back(e);
    send_frame(256, 16'd3, 1'b1, e);
    idle(2);
    @(negedge clk);
    chk("both_full_in_ready", 32'(in_ready), 0);
    chk("both_full_occupancy", 32'(occupancy), 2);
    @(posedge clk); #1;
    release_frame(1'b1);
    @(negedge clk);
    chk("after_done_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    idle(2);
    read_table(3);

    // ---- frame D (tag 4): last write coincides with frame_done on bank 0 ----
    send_frame(255, 16'd4, 1'b0, e);
    exp_fs_q.push_back(cyc + 2);
    in_valid = 1'b1; in_re = 16'd255; in_im = 16'd4; in_last = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", 32'(in_ready), 1);
    chk("simul_occ_before", 32'(occupancy), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; frame_done = 1'b0;
    @(negedge clk);
    chk("simul_occ_after", 32'(occupancy), 1);
    chk("simul_busy", 32'(busy), 0);
    @(posedge clk); #1;
    idle(2);
    read_table(4);

    // ---- truncated frame, then clean frame E (tag 5) ----
    send_frame(100, 16'd9, 1'b1, e);
    @(negedge clk);
    chk("trunc_frame_err", 32'(frame_err), 1);
    chk("trunc_occupancy", 32'(occupancy), 1);
    @(posedge clk); #1;
    send_frame(256, 16'd5, 1'b1, e);
    @(negedge clk);
    chk("E_occupancy", 32'(occupancy), 2);
    @(posedge clk); #1;
    release_frame(1'b1);
    idle(2);
    read_table(5);

    // ---- reset while BUSY with a partial frame in flight ----
    send_frame(50, 16'd7, 1'b0, e);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(in_ready), 1);
    chk("midrst_release_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1;
    send_frame(256, 16'd6, 1'b1, e);
    exp_fs_q.push_back(e);
    idle(2);
    read_table(6);

    // ---- rd_en and frame_done while IDLE are ignored ----
    release_frame(1'b0);
    idle(2);
    rd_en = 1'b1; rd_addr = 8'd1; frame_done = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0; frame_done = 1'b0;
    idle(3);
    @(negedge clk);
    chk("idle_rd_re_hold", 32'(rd_re), 192);
    chk("idle_rd_im_hold", 32'(rd_im), 6);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_occupancy", 32'(occupancy), 0);
    chk("idle_in_ready", 32'(in_ready), 1);
    idle(5);

    chk("pending_frame_start", 32'(exp_fs_q.size()), 0);
    chk("pending_reads", 32'(exp_rd_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
